// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    DEBOUNCE   = 2'd1,
    PRESSED    = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  // Hex legend printed on the keypad, indexed by (row, column).
  function automatic logic [3:0] key_map(input logic [1:0] row_idx,
                                         input logic [1:0] col_idx);
    logic [3:0] code_s;
    case ({row_idx, col_idx})
      4'h0:    code_s = 4'h1;
      4'h1:    code_s = 4'h2;
      4'h2:    code_s = 4'h3;
      4'h3:    code_s = 4'hA;
      4'h4:    code_s = 4'h4;
      4'h5:    code_s = 4'h5;
      4'h6:    code_s = 4'h6;
      4'h7:    code_s = 4'hB;
      4'h8:    code_s = 4'h7;
      4'h9:    code_s = 4'h8;
      4'hA:    code_s = 4'h9;
      4'hB:    code_s = 4'hC;
      4'hC:    code_s = 4'hE;
      4'hD:    code_s = 4'h0;
      4'hE:    code_s = 4'hF;
      4'hF:    code_s = 4'hD;
      default: code_s = 4'h0;
    endcase
    return code_s;
  endfunction

  // Index of the lowest-numbered row pulled low; only meaningful when some row is low.
  function automatic logic [1:0] lowest_low(input logic [NUM_ROWS-1:0] rows_n);
    logic [1:0] idx_s;
    if (!rows_n[0]) begin
      idx_s = 2'd0;
    end else if (!rows_n[1]) begin
      idx_s = 2'd1;
    end else if (!rows_n[2]) begin
      idx_s = 2'd2;
    end else begin
      idx_s = 2'd3;
    end
    return idx_s;
  endfunction

  // Active-low one-cold column strobe for a column index.
  function automatic logic [NUM_COLS-1:0] col_strobe(input logic [1:0] col_idx);
    return ~(4'b0001 << col_idx);
  endfunction

endpackage

// File: rtl/keypad_scanner_checker.sv
// Run-time invariants of the keypad scanner outputs.
module keypad_scanner_checker (
  input logic       clk,
  input logic       reset,
  input logic [3:0] cols,
  input logic       key_valid,
  input logic       key_held
);

  // Exactly one column strobe is driven low.
  a_one_cold_cols: assert property (@(posedge clk) disable iff (!reset) $onehot(~cols));

  // A new key is always reported as held.
  a_valid_implies_held: assert property (@(posedge clk) disable iff (!reset) key_valid |-> key_held);

  // The valid strobe never lasts more than one clock.
  a_valid_single_cycle: assert property (@(posedge clk) disable iff (!reset) !(key_valid && $past(key_valid)));

endmodule

// File: rtl/scan_tick_gen.sv
// Prescaler producing a one-clk scan tick every SCAN_DIV clock cycles.
module scan_tick_gen #(
  parameter int SCAN_DIV = 24000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] LAST     = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 2);

  logic [PW-1:0] prescaler_r;

  // Free-running prescaler counting 0..SCAN_DIV-1 and wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler_r <= '0;
    end else if (prescaler_r == LAST) begin
      prescaler_r <= '0;
    end else begin
      prescaler_r <= prescaler_r + PW'(1);
    end
  end

  // Registered tick, high exactly while the prescaler sits at its last value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick <= 1'b0;
    end else begin
      tick <= (prescaler_r == PRE_LAST);
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobing, debounce, and one key code per press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 24000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] rows,
  output logic [NUM_COLS-1:0] cols,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                key_held
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_TICKS);

  logic [NUM_ROWS-1:0] rows_meta_r;
  logic [NUM_ROWS-1:0] rows_sync_r;
  logic                tick_s;
  state_t              state_r;
  logic [1:0]          col_idx_r;
  logic [1:0]          row_idx_r;
  logic [CW-1:0]       count_r;
  logic [1:0]          next_col_s;
  logic [CW-1:0]       count_inc_s;
  logic                any_low_s;
  logic                row_low_s;

  scan_tick_gen #(
    .SCAN_DIV(SCAN_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick_s)
  );

  keypad_scanner_checker u_checker (
    .clk       (clk),
    .reset     (reset),
    .cols      (cols),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // Two-flop synchronizer for the asynchronous, pulled-up row inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rows_meta_r <= 4'hF;
      rows_sync_r <= 4'hF;
    end else begin
      rows_meta_r <= rows;
      rows_sync_r <= rows_meta_r;
    end
  end

  assign next_col_s  = col_idx_r + 2'd1;
  assign count_inc_s = count_r + CW'(1);
  assign any_low_s   = (rows_sync_r != 4'hF);
  assign row_low_s   = ~rows_sync_r[row_idx_r];

  // Scan/debounce state machine; every decision happens on a scan tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= SCAN;
      col_idx_r <= 2'd0;
      row_idx_r <= 2'd0;
      count_r   <= '0;
      cols      <= 4'b1110;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (tick_s) begin
        case (state_r)
          SCAN: begin
            if (any_low_s) begin
              // Freeze the column and remember which row to watch.
              row_idx_r <= lowest_low(rows_sync_r);
              count_r   <= '0;
              state_r   <= DEBOUNCE;
            end else begin
              col_idx_r <= next_col_s;
              cols      <= col_strobe(next_col_s);
            end
          end
          DEBOUNCE: begin
            if (row_low_s) begin
              count_r <= count_inc_s;
              if (count_inc_s == DB_LAST) begin
                state_r   <= PRESSED;
                key_valid <= 1'b1;
                key_code  <= key_map(row_idx_r, col_idx_r);
                key_held  <= 1'b1;
              end else begin
                state_r <= DEBOUNCE;
              end
            end else begin
              // Bounce: give up on this key and keep scanning.
              state_r   <= SCAN;
              col_idx_r <= next_col_s;
              cols      <= col_strobe(next_col_s);
            end
          end
          PRESSED: begin
            if (!row_low_s) begin
              count_r <= '0;
              state_r <= RELEASE_DB;
            end else begin
              state_r <= PRESSED;
            end
          end
          RELEASE_DB: begin
            if (!row_low_s) begin
              count_r <= count_inc_s;
              if (count_inc_s == DB_LAST) begin
                key_held  <= 1'b0;
                state_r   <= SCAN;
                col_idx_r <= next_col_s;
                cols      <= col_strobe(next_col_s);
              end else begin
                state_r <= RELEASE_DB;
              end
            end else begin
              // Release bounce: the key is still held, no new report.
              state_r <= PRESSED;
            end
          end
          default: begin
            state_r  <= SCAN;
            key_held <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner with a behavioural 4x4 keypad.
module tb_keypad_scanner;

  logic        clk;
  logic        reset;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed;   // bit r*4+c = key at row r, column c is held down

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int base;

  typedef struct {
    int         row;
    int         col;
    logic [3:0] code;
    logic [3:0] frozen;
    logic [3:0] resume;
  } vec_t;

  vec_t vecs[10];

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE_TICKS(3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .cols      (cols),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive keypad: a held key pulls its row low while its column is strobed.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
      end
    end
  end

  // Count every clock in which key_valid is high.
  always @(negedge clk) begin
    if (key_valid === 1'b1) pulses <= pulses + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pulses(input int target, input string name);
    int n = 0;
    while (pulses < target && n < 300) begin
      step();
      n++;
    end
    check(name, pulses, target);
  endtask

  task automatic wait_held_low(input string name);
    int n = 0;
    while (key_held !== 1'b0 && n < 300) begin
      step();
      n++;
    end
    check(name, key_held, 1'b0);
  endtask

  task automatic wait_cols(input logic [3:0] value, input string name);
    int n = 0;
    while (cols !== value && n < 300) begin
      step();
      n++;
    end
    check(name, cols, value);
  endtask

  initial begin
    logic [3:0] exp_cols;

    vecs[0] = '{0, 0, 4'h1, 4'b1110, 4'b1101};
    vecs[1] = '{1, 1, 4'h5, 4'b1101, 4'b1011};
    vecs[2] = '{2, 2, 4'h9, 4'b1011, 4'b0111};
    vecs[3] = '{3, 3, 4'hD, 4'b0111, 4'b1110};
    vecs[4] = '{0, 3, 4'hA, 4'b0111, 4'b1110};
    vecs[5] = '{3, 0, 4'hE, 4'b1110, 4'b1101};
    vecs[6] = '{3, 1, 4'h0, 4'b1101, 4'b1011};
    vecs[7] = '{2, 3, 4'hC, 4'b0111, 4'b1110};
    vecs[8] = '{1, 2, 4'h6, 4'b1011, 4'b0111};
    vecs[9] = '{3, 2, 4'hF, 4'b1011, 4'b0111};

    pressed = 16'h0000;
    reset   = 1'b1;
    #2 reset = 1'b0;
    repeat (3) step();
    check("reset cols", cols, 4'b1110);
    check("reset key_code", key_code, 4'h0);
    check("reset key_valid", key_valid, 1'b0);
    check("reset key_held", key_held, 1'b0);

    // Idle scan: each column held for four clocks.
    reset = 1'b1;
    check("scan k0", cols, 4'b1110);
    for (int k = 1; k <= 16; k++) begin
      step();
      exp_cols = 4'b1111 ^ (4'b0001 << ((k / 4) % 4));
      check($sformatf("scan k%0d", k), cols, exp_cols);
    end

    // Clean press of '5' with exact acceptance latency.
    wait_cols(4'b1101, "reach col1");
    base = pulses;
    pressed[5] = 1'b1;
    repeat (15) step();
    check("latency early", key_valid, 1'b0);
    step();
    check("latency valid", key_valid, 1'b1);
    check("press5 code", key_code, 4'h5);
    check("press5 held", key_held, 1'b1);
    check("press5 frozen", cols, 4'b1101);
    repeat (20) step();
    check("press5 one pulse", pulses - base, 1);
    check("press5 still frozen", cols, 4'b1101);
    pressed = 16'h0000;
    wait_held_low("press5 release");
    check("press5 resume col", cols, 4'b1011);

    // Bounce: '5' low for two ticks, then released.
    wait_cols(4'b1101, "bounce reach col1");
    base = pulses;
    pressed[5] = 1'b1;
    repeat (8) step();
    pressed = 16'h0000;
    repeat (4) step();
    check("bounce col advance", cols, 4'b1011);
    check("bounce no held", key_held, 1'b0);
    repeat (40) step();
    check("bounce no pulse", pulses - base, 0);

    // Table of single key presses.
    for (int i = 0; i < 10; i++) begin
      base = pulses;
      pressed = 16'h0000;
      pressed[vecs[i].row*4 + vecs[i].col] = 1'b1;
      wait_pulses(base + 1, $sformatf("vec%0d pulse", i));
      check($sformatf("vec%0d code", i), key_code, vecs[i].code);
      check($sformatf("vec%0d held", i), key_held, 1'b1);
      check($sformatf("vec%0d frozen", i), cols, vecs[i].frozen);
      repeat (12) step();
      check($sformatf("vec%0d single", i), pulses, base + 1);
      pressed = 16'h0000;
      wait_held_low($sformatf("vec%0d release", i));
      check($sformatf("vec%0d resume", i), cols, vecs[i].resume);
      check($sformatf("vec%0d code kept", i), key_code, vecs[i].code);
    end

    // Hold '5', add '9', release '5' only: '9' reported once afterwards.
    base = pulses;
    pressed = 16'h0000;
    pressed[5] = 1'b1;
    wait_pulses(base + 1, "hold5 pulse");
    check("hold5 code", key_code, 4'h5);
    pressed[10] = 1'b1;
    repeat (40) step();
    check("hold5 ignore 9", pulses, base + 1);
    check("hold5 frozen", cols, 4'b1101);
    pressed[5] = 1'b0;
    wait_pulses(base + 2, "then9 pulse");
    check("then9 code", key_code, 4'h9);
    check("then9 cols", cols, 4'b1011);
    pressed = 16'h0000;
    wait_held_low("then9 release");

    // Two rows low in column 0: lowest row wins.
    base = pulses;
    pressed = 16'h0011;
    wait_pulses(base + 1, "tworow pulse");
    check("tworow code", key_code, 4'h1);
    repeat (20) step();
    check("tworow single", pulses, base + 1);
    pressed = 16'h0000;
    wait_held_low("tworow release");

    // Reset while 'D' is held, then re-detection after reset release.
    base = pulses;
    pressed = 16'h0000;
    pressed[15] = 1'b1;
    wait_pulses(base + 1, "rstD pulse");
    check("rstD code", key_code, 4'hD);
    repeat (4) step();
    reset = 1'b0;
    #1;
    check("rstD cols", cols, 4'b1110);
    check("rstD key_code", key_code, 4'h0);
    check("rstD key_valid", key_valid, 1'b0);
    check("rstD key_held", key_held, 1'b0);
    repeat (3) step();
    base = pulses;
    reset = 1'b1;
    wait_pulses(base + 1, "rstD repulse");
    check("rstD recode", key_code, 4'hD);
    check("rstD reheld", key_held, 1'b1);
    repeat (20) step();
    check("rstD single", pulses, base + 1);
    pressed = 16'h0000;
    wait_held_low("rstD release");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad and reports one debounced key press per physical press.
- Clocked by the 24 MHz halved oscillator from the clock divider directly upstream.
- Drives active-low column strobes and reads active-low, pulled-up row inputs.
- Emits a 4-bit hex key code with a single-cycle valid pulse, consumed by the display/digit-shift logic downstream.

Parameters:
- SCAN_DIV, 24000, clk cycles per scan tick (1 kHz at 24 MHz); must be >= 2.
- DEBOUNCE_TICKS, 20, consecutive stable scan ticks required to accept a press or a release; must be >= 1.

Ports:
- clk  input  1  24 MHz halved oscillator.
- reset  input  1  asynchronous, active-low.
- rows  input  4  keypad rows, active-low, asynchronous to clk.
- cols  output  4  column strobes, exactly one bit low at any time.
- key_code  output  4  hex value of the last accepted key.
- key_valid  output  1  one-clk pulse when a new key is accepted.
- key_held  output  1  high while the accepted key remains pressed, until its release debounce completes.

Behaviour:
- Reset values (asynchronous, while reset=0):
  - cols=4'b1110, key_code=0, key_valid=0, key_held=0.
  - state=SCAN, prescaler=0, debounce count=0.
  - Row synchronizer flops = 4'hF.
- Synchronizer: rows pass through 2 flops before use. All decisions use the synchronized value, sampled only on tick cycles.
- Tick generator: prescaler counts 0..SCAN_DIV-1 and wraps. tick=1 for one clk when prescaler==SCAN_DIV-1. Prescaler width is $clog2(SCAN_DIV).
- Column sequence: col index 0→1→2→3→0. cols = ~(1<<idx). The column advances only on a tick while in SCAN.
  - Rows are therefore sampled one full tick period after a column is driven.
- State SCAN:
  - On tick with synced rows==4'hF: advance the column.
  - On tick with any row low: latch row = lowest-index low bit, latch col = current idx. Clear the count, go to DEBOUNCE. The column is frozen.
- State DEBOUNCE (latched row watched on each tick):
  - Row low: count+1. When count reaches DEBOUNCE_TICKS, go to PRESSED. On that same cycle assert key_valid for one clk, load key_code from the map, set key_held=1.
  - Row high: return to SCAN and advance the column. No valid pulse.
- State PRESSED: column stays frozen. On tick with the latched row high, clear the count and go to RELEASE_DB.
- State RELEASE_DB:
  - Tick with row high: count+1. At DEBOUNCE_TICKS, clear key_held, go to SCAN, advance the column.
  - Tick with row low: return to PRESSED, no new key_valid.
- Other keys while in DEBOUNCE/PRESSED/RELEASE_DB are ignored; only the latched row/col is observed.
- key_code holds its value until the next accepted key.
- Key map (row r, col c), hex:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- Latency: a clean press is accepted DEBOUNCE_TICKS ticks after first detection. key_valid rises on the clk edge following the final counting tick.
- Reset mid-operation: immediate return to reset values. A still-held key is re-detected and re-debounced after reset release, producing one new key_valid.

Decomposition:
- Package keypad_pkg:
  - state enum {SCAN, DEBOUNCE, PRESSED, RELEASE_DB}.
  - NUM_ROWS=4, NUM_COLS=4.
  - Function key_map(row_idx, col_idx) returning the 4-bit code.
- Sub-module scan_tick_gen (parameter SCAN_DIV; ports clk, reset, tick) holds the prescaler.
- The 2-flop synchronizer and FSM stay in keypad_scanner.

Test Plan (SCAN_DIV=4, DEBOUNCE_TICKS=3):
- Assert reset=0 for 3 clks → cols=1110, key_code=0, key_valid=0, key_held=0. Release reset with rows=1111 → cols step 1110→1101→1011→0111→1110, each held 4 clks.
- Press '5' (rows[1]=0 whenever cols[1]=0), held → exactly one key_valid pulse, key_code=5, key_held=1, cols frozen at 1101. Release → key_held=0 after 3 high ticks, scan resumes at 1011.
- Bounce: '5' low for 2 ticks, then high → no key_valid, state SCAN, column advances to 1011.
- Hold '5', then also press '9' (row2/col2) → no second pulse. Release '5' only → after release debounce, scanning reaches col2, one key_valid with key_code=9.
- Two rows low in the same column (rows=1100 at col0) → key_code=1 (lowest row wins), one pulse.
- reset=0 while PRESSED on 'D' → outputs return to reset values within the same cycle. Release reset with 'D' still held → one new key_valid, key_code=D.
